mem_access_unit: RTL and testbench

Load/store unit between the EX/MEM pipeline register and the word-wide data_memory; sole master of data_memory ports.
- Turns byte/halfword/word load/store requests into word accesses.
- Sub-word stores use a 2-cycle read-modify-write.
- Loads are lane-extracted and sign/zero-extended.
- Misaligned accesses are flagged and never reach memory.
- Drives a pipeline stall while busy.

---
 rtl/mem_access_pkg.sv | 55 +++++
 rtl/mem_align_check.sv | 43 ++++
 rtl/mem_access_unit.sv | 156 +++++++++++++++
 tb/tb_mem_access_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// mem_access_pkg
//   Shared definitions for the load/store unit: access-size encodings,
//   the unit's FSM state type, and the lane helpers that turn a 32-bit
//   memory word into a load result and merge sub-word store data into
//   a 32-bit word. Data width is fixed at 32 bits.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RMW_WR = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Pick the addressed byte/half out of a little-endian word and extend it.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  lo,
                                               input logic [1:0]  size,
                                               input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = {{24{sgn & b[7]}}, b};
      SZ_HALF: r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed lane(s) of the old word with right-justified store data.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  lo,
                                             input logic [1:0]  size);
    logic [31:0] r;
    r = old_word;
    case (size)
      SZ_BYTE: r[{lo, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF: begin
        if (lo[1]) r[31:16] = wdata[15:0];
        else       r[15:0]  = wdata[15:0];
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_align_check.sv
// mem_align_check
//   Combinational decode of an access's size and low address bits.
//   Ports:
//     size       in  2  requested access size (SZ_*)
//     addr_lo    in  2  request address bits [1:0]
//     misaligned out 1  half on odd address, word not on a word boundary,
//                       or reserved size
//     eff_size   out 2  size actually performed (reserved maps to word)
//     eff_lo     out 2  lane offset with the low bits cleared to natural
//                       alignment (used when misalignment is not an error)
module mem_align_check
  import mem_access_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic       misaligned,
  output logic [1:0] eff_size,
  output logic [1:0] eff_lo
);

  always_comb begin
    misaligned = 1'b0;
    eff_size   = size;
    eff_lo     = addr_lo;
    case (size)
      SZ_HALF: begin
        misaligned = addr_lo[0];
        eff_lo     = {addr_lo[1], 1'b0};
      end
      SZ_WORD: begin
        misaligned = |addr_lo;
        eff_lo     = 2'b00;
      end
      SZ_RSVD: begin
        misaligned = 1'b1;
        eff_size   = SZ_WORD;
        eff_lo     = 2'b00;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store unit between the EX/MEM pipeline register and a word-wide
//   data memory with combinational read. Loads and word stores take one
//   cycle to respond; byte/half stores do a read-modify-write and take two.
//   Misaligned or reserved-size accesses never touch memory when
//   ERR_ON_MISALIGN=1; with 0 the address is force-aligned instead.
//   Optional: define MEM_ACCESS_STATS_EN to add saturating access counters.
//   Ports:
//     clk, reset_n                      clock, async active-low reset
//     req_valid/req_ready               request handshake (ready only in IDLE)
//     req_write/size/signed/addr/wdata  request fields
//     resp_valid/resp_rdata/resp_err    one-cycle response
//     stall                             pipeline hold while busy
//     mem_read_en/write_en/addr/write_data/read_data   data memory port
//     stat_loads/stat_stores/stat_errs  (MEM_ACCESS_STATS_EN only)
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int ERR_ON_MISALIGN = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              stall,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
`ifdef MEM_ACCESS_STATS_EN
  ,
  output logic [15:0]       stat_loads,
  output logic [15:0]       stat_stores,
  output logic [15:0]       stat_errs
`endif
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] merged_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              err_reg;

  logic       misaligned;
  logic [1:0] eff_size;
  logic [1:0] eff_lo;
  logic       req_err;
  logic       req_rmw;
  logic       handshake;
  logic       rd_en, wr_en;

  mem_align_check u_align (
    .size       (req_size),
    .addr_lo    (req_addr[1:0]),
    .misaligned (misaligned),
    .eff_size   (eff_size),
    .eff_lo     (eff_lo)
  );

  assign req_err   = (ERR_ON_MISALIGN != 0) && misaligned;
  assign req_rmw   = req_write && !req_err && (eff_size != SZ_WORD);
  assign req_ready = (state_reg == IDLE);
  assign handshake = req_valid && req_ready;

  always_comb begin
    state_next     = state_reg;
    rd_en          = 1'b0;
    wr_en          = 1'b0;
    mem_addr       = {req_addr[ADDR_W-1:2], 2'b00};
    mem_write_data = req_wdata;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          // Sub-word stores read the old word now and write it back next cycle.
          if (!req_err) begin
            if (!req_write || req_rmw) rd_en = 1'b1;
            else                       wr_en = 1'b1;
          end
          state_next = req_rmw ? RMW_WR : RESP;
        end
      end
      RMW_WR: begin
        wr_en          = 1'b1;
        mem_addr       = addr_reg;
        mem_write_data = merged_reg;
        state_next     = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Gating with reset_n keeps an interrupted read-modify-write from writing.
  assign mem_read_en  = rd_en && reset_n;
  assign mem_write_en = wr_en && reset_n;
  assign stall        = reset_n && ((req_valid && req_rmw) || (state_reg != IDLE));
  assign resp_valid   = (state_reg == RESP);
  assign resp_rdata   = rdata_reg;
  assign resp_err     = err_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      merged_reg <= '0;
      rdata_reg  <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (handshake) begin
        addr_reg   <= {req_addr[ADDR_W-1:2], 2'b00};
        err_reg    <= req_err;
        merged_reg <= lane_merge(mem_read_data, req_wdata, eff_lo, eff_size);
        rdata_reg  <= (!req_write && !req_err)
                      ? lane_extract(mem_read_data, eff_lo, eff_size, req_signed)
                      : '0;
      end
    end
  end

`ifdef MEM_ACCESS_STATS_EN
  logic write_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      write_reg   <= 1'b0;
      stat_loads  <= '0;
      stat_stores <= '0;
      stat_errs   <= '0;
    end else begin
      if (handshake) write_reg <= req_write;
      if (state_reg == RESP) begin
        if (err_reg) begin
          if (stat_errs != 16'hFFFF) stat_errs <= stat_errs + 16'd1;
        end else if (write_reg) begin
          if (stat_stores != 16'hFFFF) stat_stores <= stat_stores + 16'd1;
        end else begin
          if (stat_loads != 16'hFFFF) stat_loads <= stat_loads + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_signed     (req_signed),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .stall          (stall),
    .mem_read_en    (mem_read_en),
    .mem_write_en   (mem_write_en),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  // Word-wide data memory with combinational read.
  logic [31:0] mem [0:63];
  assign mem_read_data = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_write_en) mem[mem_addr[7:2]] <= mem_write_data;

  // Reference model: flat byte-addressed memory.
  logic [7:0] ref_bytes [0:255];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_access(input logic wr, input logic [1:0] size, input logic sgn,
                              input logic [7:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata, output logic err, output int lat);
    int n;
    err   = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
    rdata = '0;
    lat   = 1;
    if (!err) begin
      n = 1 << size;
      if (wr) begin
        for (int i = 0; i < n; i++) ref_bytes[int'(addr) + i] = wdata[8*i +: 8];
        lat = (n < 4) ? 2 : 1;
      end else begin
        for (int i = 0; i < n; i++) rdata[8*i +: 8] = ref_bytes[int'(addr) + i];
        if (sgn && n < 4 && rdata[8*n-1])
          for (int i = n; i < 4; i++) rdata[8*i +: 8] = 8'hFF;
      end
    end
  endtask

  function automatic logic [31:0] model_word(input int idx);
    return {ref_bytes[4*idx+3], ref_bytes[4*idx+2], ref_bytes[4*idx+1], ref_bytes[4*idx]};
  endfunction

  // One transaction from an idle unit: checks accept-cycle stall, latency,
  // response data/error and memory-port sanity.
  task automatic do_req(input string tag, input logic wr, input logic [1:0] size,
                        input logic sgn, input logic [7:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    int   lat;
    int   viol;
    logic rmw;
    viol = 0;
    rmw  = wr && (size < 2'd2) && !exp_err;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = size;
    req_signed = sgn;
    req_addr   = {24'h0, addr};
    req_wdata  = wdata;
    #1;
    check({tag, " stall_at_accept"}, {31'h0, stall}, {31'h0, rmw});
    if (!req_ready) viol++;
    if (mem_read_en && mem_write_en) viol++;
    if (exp_err && (mem_read_en || mem_write_en)) viol++;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (mem_read_en && mem_write_en) viol++;
      if (exp_err && (mem_read_en || mem_write_en)) viol++;
      if (stall !== 1'b1 || req_ready !== 1'b0) viol++;
      if (resp_valid || lat >= 8) break;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " rdata"}, resp_rdata, exp_rdata);
    check({tag, " err"}, {31'h0, resp_err}, {31'h0, exp_err});
    check({tag, " port_violations"}, viol, 0);
    $display("txn %s wr=%0d size=%0d sgn=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
             tag, wr, size, sgn, addr, wdata, resp_rdata, resp_err, lat);
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [16];

  initial begin
    logic [31:0] e_rdata;
    logic        e_err;
    int          e_lat;
    logic [7:0]  b2b_addr [3];
    logic [31:0] b2b_exp [3];
    int          n_acc, n_resp, last_cyc;
    logic        rdy, hs;

    vecs[0]  = '{1'b0, 2'd0, 1'b0, 8'h00, 32'h0,        32'h000000A0, 1'b0, 1};
    vecs[1]  = '{1'b0, 2'd0, 1'b1, 8'h00, 32'h0,        32'hFFFFFFA0, 1'b0, 1};
    vecs[2]  = '{1'b1, 2'd2, 1'b0, 8'h08, 32'hCAFEF00D, 32'h0,        1'b0, 1};
    vecs[3]  = '{1'b1, 2'd0, 1'b0, 8'h09, 32'h0000005A, 32'h0,        1'b0, 2};
    vecs[4]  = '{1'b0, 2'd2, 1'b0, 8'h08, 32'h0,        32'hCAFE5A0D, 1'b0, 1};
    vecs[5]  = '{1'b1, 2'd2, 1'b0, 8'h0C, 32'hDEADBEEF, 32'h0,        1'b0, 1};
    vecs[6]  = '{1'b0, 2'd1, 1'b1, 8'h0E, 32'h0,        32'hFFFFDEAD, 1'b0, 1};
    vecs[7]  = '{1'b0, 2'd1, 1'b0, 8'h0C, 32'h0,        32'h0000BEEF, 1'b0, 1};
    vecs[8]  = '{1'b0, 2'd2, 1'b0, 8'h06, 32'h0,        32'h0,        1'b1, 1};
    vecs[9]  = '{1'b1, 2'd1, 1'b0, 8'h03, 32'h0000BEEF, 32'h0,        1'b1, 1};
    vecs[10] = '{1'b0, 2'd0, 1'b1, 8'h0B, 32'h0,        32'hFFFFFFCA, 1'b0, 1};
    vecs[11] = '{1'b1, 2'd1, 1'b0, 8'h0E, 32'hAAAA1234, 32'h0,        1'b0, 2};
    vecs[12] = '{1'b0, 2'd2, 1'b0, 8'h0C, 32'h0,        32'h1234BEEF, 1'b0, 1};
    vecs[13] = '{1'b0, 2'd3, 1'b0, 8'h00, 32'h0,        32'h0,        1'b1, 1};
    vecs[14] = '{1'b0, 2'd1, 1'b1, 8'h08, 32'h0,        32'h00005A0D, 1'b0, 1};
    vecs[15] = '{1'b0, 2'd0, 1'b0, 8'h0A, 32'h0,        32'h000000FE, 1'b0, 1};

    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0] = 32'h000000A0;
    mem[1] = 32'h11223344;
    for (int i = 0; i < 256; i++) ref_bytes[i] = 8'h00;
    ref_bytes[0] = 8'hA0;
    {ref_bytes[7], ref_bytes[6], ref_bytes[5], ref_bytes[4]} = 32'h11223344;

    // Reset: memory enables and stall gated off even with a request present.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_size  = 2'd2;
    repeat (2) @(posedge clk);
    #1;
    check("reset mem_read_en", {31'h0, mem_read_en}, 32'h0);
    check("reset stall", {31'h0, stall}, 32'h0);
    req_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("reset resp_valid", {31'h0, resp_valid}, 32'h0);
    check("reset resp_rdata", resp_rdata, 32'h0);
    check("reset resp_err", {31'h0, resp_err}, 32'h0);
    check("reset req_ready", {31'h0, req_ready}, 32'h1);

    // Directed vector table.
    for (int i = 0; i < 16; i++) begin
      model_access(vecs[i].wr, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                   e_rdata, e_err, e_lat);
      do_req($sformatf("vec%0d", i), vecs[i].wr, vecs[i].size, vecs[i].sgn, vecs[i].addr,
             vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat);
    end
    check("misaligned word@4 untouched", mem[1], 32'h11223344);

    // Reset while the write half of a byte RMW is pending: write must not happen.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = 2'd0;
    req_addr  = 32'h9;
    req_wdata = 32'hFF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("rmw_abort stall in rmw", {31'h0, stall}, 32'h1);
    check("rmw_abort write pending", {31'h0, mem_write_en}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("rmw_abort write gated", {31'h0, mem_write_en}, 32'h0);
    check("rmw_abort resp_valid", {31'h0, resp_valid}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("rmw_abort word@8", mem[2], model_word(2));
    check("rmw_abort idle", {31'h0, req_ready}, 32'h1);
    reset_n = 1'b1;
    @(negedge clk);
    check("rmw_abort no resp", {31'h0, resp_valid}, 32'h0);
    $display("txn rmw_abort word@8=%h", mem[2]);

    // Back-to-back loads with req_valid held high.
    b2b_addr[0] = 8'h00;
    b2b_addr[1] = 8'h08;
    b2b_addr[2] = 8'h0C;
    for (int i = 0; i < 3; i++) model_access(1'b0, 2'd2, 1'b0, b2b_addr[i], 32'h0, b2b_exp[i], e_err, e_lat);
    n_acc = 0;
    n_resp = 0;
    last_cyc = -10;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_size  = 2'd2;
    req_addr  = {24'h0, b2b_addr[0]};
    for (int cyc = 0; cyc < 20 && n_resp < 3; cyc++) begin
      #1;
      rdy = req_ready;
      hs  = rdy && req_valid;
      if (resp_valid) begin
        check($sformatf("b2b%0d rdata", n_resp), resp_rdata, b2b_exp[n_resp]);
        check($sformatf("b2b%0d ready_in_resp", n_resp), {31'h0, rdy}, 32'h0);
        if (n_resp > 0) check($sformatf("b2b%0d spacing", n_resp), cyc - last_cyc, 2);
        $display("txn b2b%0d rdata=%h cycle=%0d", n_resp, resp_rdata, cyc);
        last_cyc = cyc;
        n_resp++;
      end
      @(posedge clk);
      if (hs) n_acc++;
      @(negedge clk);
      if (hs) begin
        if (n_acc < 3) req_addr = {24'h0, b2b_addr[n_acc]};
        else           req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    check("b2b responses", n_resp, 3);
    check("b2b accepts", n_acc, 3);

    // Randomized traffic against the byte-array model.
    for (int i = 0; i < 80; i++) begin
      logic        r_wr, r_sgn;
      logic [1:0]  r_size;
      logic [7:0]  r_addr;
      logic [31:0] r_wdata;
      r_wr    = 1'($urandom_range(0, 1));
      r_sgn   = 1'($urandom_range(0, 1));
      r_size  = 2'($urandom_range(0, 3));
      r_addr  = 8'($urandom_range(0, 63));
      r_wdata = $urandom;
      model_access(r_wr, r_size, r_sgn, r_addr, r_wdata, e_rdata, e_err, e_lat);
      do_req($sformatf("rnd%0d", i), r_wr, r_size, r_sgn, r_addr, r_wdata, e_rdata, e_err, e_lat);
    end

    @(negedge clk);
    for (int i = 0; i < 16; i++) check($sformatf("final word%0d", i), mem[i], model_word(i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
